// File: rtl/abcd_sweep_sequencer_if.sv
// Stimulus/capture bus between the sweep sequencer and the 4-input block under test.
// The master side belongs to the sequencer; the slave side belongs to whatever hosts the block.
interface abcd_sweep_sequencer_if;
   logic        start;
   logic        y;
   logic        a;
   logic        b;
   logic        c;
   logic        d;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] table_out;
   logic        fail_valid;
   logic [3:0]  fail_idx;

   modport master (
      input  start, y,
      output a, b, c, d, busy, done, pass, table_out, fail_valid, fail_idx
   );

   modport slave (
      output start, y,
      input  a, b, c, d, busy, done, pass, table_out, fail_valid, fail_idx
   );
endinterface

// File: rtl/abcd_sweep_sequencer.sv
// Sweeps all 16 {a,b,c,d} combinations into a combinational block and captures y into a truth table.
// It then checks the captured table against EXPECTED and latches the first failing vector index.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | stimulus parked at 0, waiting for start
// S_DRIVE | vector vec_q on a..d; sample y when the hold timer hits zero
// S_DONE  | sweep finished; table and fail info held; start re-arms
module abcd_sweep_sequencer #(
   parameter int unsigned HOLD_CYCLES  = 1,
   parameter logic [15:0] EXPECTED     = 16'h0000,
   parameter bit          STOP_ON_FAIL = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   abcd_sweep_sequencer_if.master bus
);

   generate
      if (HOLD_CYCLES < 1) begin : g_bad_hold
         $error("abcd_sweep_sequencer: HOLD_CYCLES must be >= 1");
      end
   endgenerate

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [15:0]   GOLDEN    = EXPECTED;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        state_q,      state_d;
   logic [3:0]    vec_q,        vec_d;
   logic [HW-1:0] hold_cnt_q,   hold_cnt_d;
   logic [15:0]   table_q,      table_d;
   logic          fail_valid_q, fail_valid_d;
   logic [3:0]    fail_idx_q,   fail_idx_d;
   logic [3:0]    abcd_q,       abcd_d;
   logic          busy_q,       busy_d;
   logic          done_q,       done_d;
   logic          pass_q,       pass_d;
   logic          mismatch;

   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      hold_cnt_d   = hold_cnt_q;
      table_d      = table_q;
      fail_valid_d = fail_valid_q;
      fail_idx_d   = fail_idx_q;
      mismatch     = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d      = S_DRIVE;
               vec_d        = 4'd0;
               hold_cnt_d   = HOLD_LOAD;
               table_d      = 16'h0000;
               fail_valid_d = 1'b0;
               fail_idx_d   = 4'd0;
            end
         end
         S_DRIVE: begin
            // Hold timer counts down; y is sampled on its terminal count.
            if (hold_cnt_q == '0) begin
               table_d[vec_q] = bus.y;
               mismatch       = (bus.y != GOLDEN[vec_q]);
               if (mismatch && !fail_valid_q) begin
                  fail_valid_d = 1'b1;
                  fail_idx_d   = vec_q;
               end
               if (vec_q == 4'd15 || (STOP_ON_FAIL && mismatch)) begin
                  state_d = S_DONE;
               end else begin
                  vec_d      = vec_q + 4'd1;
                  hold_cnt_d = HOLD_LOAD;
               end
            end else begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next-state view so they align with the state they describe.
      abcd_d = (state_d == S_DRIVE) ? vec_d : 4'd0;
      busy_d = (state_d == S_DRIVE);
      done_d = (state_d == S_DONE);
      pass_d = (state_d == S_DONE) && !fail_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         vec_q        <= 4'd0;
         hold_cnt_q   <= '0;
         table_q      <= 16'h0000;
         fail_valid_q <= 1'b0;
         fail_idx_q   <= 4'd0;
         abcd_q       <= 4'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         hold_cnt_q   <= hold_cnt_d;
         table_q      <= table_d;
         fail_valid_q <= fail_valid_d;
         fail_idx_q   <= fail_idx_d;
         abcd_q       <= abcd_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   assign bus.a          = abcd_q[3];
   assign bus.b          = abcd_q[2];
   assign bus.c          = abcd_q[1];
   assign bus.d          = abcd_q[0];
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.table_out  = table_q;
   assign bus.fail_valid = fail_valid_q;
   assign bus.fail_idx   = fail_idx_q;

endmodule

// File: tb/tb_abcd_sweep_sequencer.sv
// Self-checking bench: three sequencer instances (hold 1, hold 1 with stop-on-fail, hold 3),
// each fed by a lookup into a programmable ACTUAL table, checked against a queue-based scoreboard.
module tb_abcd_sweep_sequencer;

   logic clk;
   logic rst_n;

   logic [2:0]        start_v;
   logic [2:0][15:0]  actual_v;
   logic [2:0][3:0]   abcd_v;
   logic [2:0]        busy_v;
   logic [2:0]        done_v;
   logic [2:0]        pass_v;
   logic [2:0][15:0]  tbl_v;
   logic [2:0]        fv_v;
   logic [2:0][3:0]   fidx_v;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         abcd_sweep_sequencer_if sif ();

         abcd_sweep_sequencer #(
            .HOLD_CYCLES  ((g == 2) ? 3 : 1),
            .EXPECTED     (16'h8001),
            .STOP_ON_FAIL ((g == 1) ? 1'b1 : 1'b0)
         ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sif.master)
         );

         assign sif.start   = start_v[g];
         assign sif.y       = actual_v[g][{sif.a, sif.b, sif.c, sif.d}];
         assign abcd_v[g]   = {sif.a, sif.b, sif.c, sif.d};
         assign busy_v[g]   = sif.busy;
         assign done_v[g]   = sif.done;
         assign pass_v[g]   = sif.pass;
         assign tbl_v[g]    = sif.table_out;
         assign fv_v[g]     = sif.fail_valid;
         assign fidx_v[g]   = sif.fail_idx;
      end
   endgenerate

   // Runs one sweep on instance g. abort_at >= 0 pulls rst_n low after that cycle's check;
   // extra_at >= 0 raises start for one cycle mid-sweep.
   task automatic run_sweep(input int g, input int hold, input bit stop,
                            input logic [15:0] golden, input int extra_at,
                            input int abort_at, input string name);
      int          m;
      int          nvec;
      int          t;
      logic [15:0] etbl;
      logic        efv;
      logic [3:0]  efi;
      logic [3:0]  ev;
      logic [15:0] act;

      act = actual_v[g];
      m   = -1;
      for (int i = 0; i < 16; i++)
         if (act[i] !== golden[i] && m < 0) m = i;
      nvec = (stop && m >= 0) ? m + 1 : 16;
      etbl = 16'h0000;
      for (int i = 0; i < nvec; i++) etbl[i] = act[i];
      efv = (m >= 0);
      efi = (m >= 0) ? 4'(m) : 4'd0;

      exp_q.delete();
      for (int v = 0; v < nvec; v++)
         for (int h = 0; h < hold; h++) exp_q.push_back(4'(v));

      @(negedge clk);
      start_v[g] = 1'b1;
      t = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         ev = exp_q.pop_front();
         n_vec++;
         if (abcd_v[g] !== ev || busy_v[g] !== 1'b1 || done_v[g] !== 1'b0) begin
            n_err++;
            $display("FAIL %s drive t=%0d: abcd=%h busy=%b done=%b, required abcd=%h busy=1 done=0",
                     name, t, abcd_v[g], busy_v[g], done_v[g], ev);
         end
         start_v[g] = (t == extra_at);
         if (t == abort_at) begin
            #2 rst_n = 1'b0;
            #1;
            n_vec++;
            if (abcd_v[g] !== 4'd0 || busy_v[g] !== 1'b0 || tbl_v[g] !== 16'h0000 ||
                fv_v[g] !== 1'b0 || done_v[g] !== 1'b0) begin
               n_err++;
               $display("FAIL %s async reset: abcd=%h busy=%b table=%h fv=%b done=%b, required all 0",
                        name, abcd_v[g], busy_v[g], tbl_v[g], fv_v[g], done_v[g]);
            end
            exp_q.delete();
            return;
         end
         t++;
      end

      @(negedge clk);
      n_vec++;
      if (done_v[g] !== 1'b1 || busy_v[g] !== 1'b0 || abcd_v[g] !== 4'd0) begin
         n_err++;
         $display("FAIL %s done timing: done=%b busy=%b abcd=%h, required done=1 busy=0 abcd=0",
                  name, done_v[g], busy_v[g], abcd_v[g]);
      end
      n_vec++;
      if (tbl_v[g] !== etbl) begin
         n_err++;
         $display("FAIL %s table_out: got %h, required %h", name, tbl_v[g], etbl);
      end
      n_vec++;
      if (fv_v[g] !== efv || (efv && fidx_v[g] !== efi)) begin
         n_err++;
         $display("FAIL %s fail info: fail_valid=%b fail_idx=%0d, required fail_valid=%b fail_idx=%0d",
                  name, fv_v[g], fidx_v[g], efv, efi);
      end
      n_vec++;
      if (pass_v[g] !== !efv) begin
         n_err++;
         $display("FAIL %s pass: got %b, required %b", name, pass_v[g], !efv);
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      start_v  = 3'b111;
      actual_v = '{16'h8001, 16'h8001, 16'h8001};
      #2;
      for (int g = 0; g < 3; g++) begin
         n_vec++;
         if (abcd_v[g] !== 4'd0 || busy_v[g] !== 1'b0 || done_v[g] !== 1'b0 || pass_v[g] !== 1'b0 ||
             tbl_v[g] !== 16'h0000 || fv_v[g] !== 1'b0 || fidx_v[g] !== 4'd0) begin
            n_err++;
            $display("FAIL reset dut%0d: abcd=%h busy=%b done=%b pass=%b table=%h fv=%b fidx=%0d, required all 0",
                     g, abcd_v[g], busy_v[g], done_v[g], pass_v[g], tbl_v[g], fv_v[g], fidx_v[g]);
         end
      end
      @(negedge clk);
      start_v = 3'b000;
      rst_n   = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            n_vec++;
            if (abcd_v[g] !== 4'd0 || busy_v[g] !== 1'b0 || done_v[g] !== 1'b0) begin
               n_err++;
               $display("FAIL idle dut%0d cycle %0d: abcd=%h busy=%b done=%b, required 0 0 0",
                        g, c, abcd_v[g], busy_v[g], done_v[g]);
            end
         end
      end
   endtask

   task automatic test_full_pass();
      actual_v[0] = 16'h8001;
      run_sweep(0, 1, 1'b0, 16'h8001, -1, -1, "full_pass");
   endtask

   task automatic test_mismatch_full();
      actual_v[0] = 16'h8021;
      run_sweep(0, 1, 1'b0, 16'h8001, -1, -1, "mismatch_full");
      actual_v[0] = 16'h8421;
      run_sweep(0, 1, 1'b0, 16'h8001, -1, -1, "first_mismatch_only");
   endtask

   task automatic test_stop_on_fail();
      actual_v[1] = 16'h8021;
      run_sweep(1, 1, 1'b1, 16'h8001, -1, -1, "stop_on_fail");
      actual_v[1] = 16'h0001;
      run_sweep(1, 1, 1'b1, 16'h8001, -1, -1, "stop_at_last");
   endtask

   task automatic test_hold3_restart();
      actual_v[2] = 16'h8001;
      run_sweep(2, 3, 1'b0, 16'h8001, 12, -1, "hold3_start_busy");
      run_sweep(2, 3, 1'b0, 16'h8001, -1, -1, "hold3_restart_from_done");
   endtask

   task automatic test_reset_mid_sweep();
      actual_v[0] = 16'h8001;
      run_sweep(0, 1, 1'b0, 16'h8001, -1, 7, "reset_mid_sweep");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_sweep(0, 1, 1'b0, 16'h8001, -1, -1, "after_reset_sweep");
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_mismatch_full();
      test_stop_on_fail();
      test_hold3_restart();
      test_reset_mid_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
